// File: rtl/periph_bus_fabric.sv
`default_nettype none
// periph_bus_fabric: address-decoded interconnect from the core data port to NUM_SLV slave slots,
// with registered read-response routing, per-read timeout, unmapped-access errors and error capture.
module periph_bus_fabric #(
  parameter int              XLEN     = 32,
  parameter int              NUM_SLV  = 4,
  parameter int              ADDRW    = 12,
  parameter int              SLOT_LSB = 10,
  parameter int              TIMEOUT  = 15,
  parameter logic [XLEN-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         m_addr,
  input  logic [XLEN-1:0]         m_wrData,
  input  logic                    m_wrEn,
  input  logic                    m_rdEn,
  input  logic [3:0]              m_mode,
  output logic [XLEN-1:0]         m_rdata,
  output logic                    m_rdataEn,
  output logic                    m_err,
  output logic                    m_busy,
  output logic [ADDRW-1:0]        s_addr,
  output logic [XLEN-1:0]         s_wrData,
  output logic [3:0]              s_mode,
  output logic [NUM_SLV-1:0]      s_wrEn,
  output logic [NUM_SLV-1:0]      s_rdEn,
  input  logic [NUM_SLV*XLEN-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]      s_outEn,
  output logic [XLEN-1:0]         err_addr,
  output logic [7:0]              err_cnt
);

  localparam int SLOTW = ADDRW - SLOT_LSB;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [SLOTW-1:0]  slot;
  logic [SLOTW-1:0]  pend;
  logic [7:0]        cnt;
  logic [XLEN-1:0]   req_addr;
  logic              mapped;
  logic              pend_valid;
  logic [XLEN-1:0]   pend_data;
  logic              rd_accept;
  logic              rsp_ok;
  logic              rsp_err;
  logic              wr_err;

  assign slot     = m_addr[ADDRW-1:SLOT_LSB];
  assign mapped   = (m_addr[XLEN-1:ADDRW] == '0) && (32'(slot) < NUM_SLV);
  assign m_busy   = (state != S_IDLE);
  assign s_addr   = m_addr[ADDRW-1:0];
  assign s_wrData = m_wrData;
  assign s_mode   = m_mode;

  always_comb begin
    s_wrEn = '0;
    s_rdEn = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      s_wrEn[k] = !rst && !m_busy && mapped && m_wrEn && (slot == SLOTW'(k));
      s_rdEn[k] = !rst && !m_busy && mapped && m_rdEn && (slot == SLOTW'(k));
    end
  end

  // Only the slot that owns the outstanding read may complete it.
  always_comb begin
    pend_valid = 1'b0;
    pend_data  = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (pend == SLOTW'(k)) begin
        pend_valid = s_outEn[k];
        pend_data  = s_rdata[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Error responses are registered on the transition itself, so the
  // state is already IDLE in the cycle the pulse is visible.
  always_comb begin
    state_nxt = state;
    rd_accept = 1'b0;
    rsp_ok    = 1'b0;
    rsp_err   = 1'b0;
    wr_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (m_rdEn) begin
          if (mapped) begin
            rd_accept = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            rsp_err = 1'b1;
          end
        end else if (m_wrEn && !mapped) begin
          wr_err = 1'b1;
        end
      end
      S_WAIT: begin
        if (pend_valid) begin
          rsp_ok    = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          rsp_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_rdata   <= '0;
      m_rdataEn <= 1'b0;
      m_err     <= 1'b0;
      pend      <= '0;
      cnt       <= '0;
      req_addr  <= '0;
      err_addr  <= '0;
      err_cnt   <= '0;
    end else begin
      m_rdataEn <= rsp_ok | rsp_err;
      m_err     <= rsp_err | wr_err;
      if (rsp_ok)       m_rdata <= pend_data;
      else if (rsp_err) m_rdata <= ERR_DATA;
      if (rd_accept) begin
        pend     <= slot;
        req_addr <= m_addr;
        cnt      <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (rsp_err | wr_err) begin
        err_addr <= (state == S_IDLE) ? m_addr : req_addr;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/periph_bus_fabric.md
# periph_bus_fabric

Parametrised memory-mapped interconnect between the rv32i core data port and NUM_SLV peripheral slots (RAM, UART, IO port and future blocks). It replaces the fixed three-way priority mux and the ad-hoc RAM/peripheral read gating of the current SoC top. It adds registered read-response routing, a per-transaction slave timeout, unmapped-address detection, and error-capture registers.

## Interface
- XLEN, 32, data width
- NUM_SLV, 4, number of slave slots (1..8)
- ADDRW, 12, decoded byte-address width; m_addr bits above ADDRW-1 must be zero for a mapped access
- SLOT_LSB, 10, slot index = m_addr[ADDRW-1:SLOT_LSB]; requires 2^(ADDRW-SLOT_LSB) >= NUM_SLV
- TIMEOUT, 15, maximum slave read latency in cycles (1..255)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an error response
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_addr  in  XLEN  core byte address
- m_wrData  in  XLEN  core write data
- m_wrEn  in  1  core write strobe (single cycle)
- m_rdEn  in  1  core read strobe (single cycle)
- m_mode  in  4  byte/half/word/unsigned mode, passed through
- m_rdata  out  XLEN  read response data
- m_rdataEn  out  1  read response valid (one-cycle pulse)
- m_err  out  1  error pulse (coincident with m_rdataEn for reads, or alone for writes)
- m_busy  out  1  read outstanding; new requests are ignored while high
- s_addr  out  ADDRW  shared slave address = m_addr[ADDRW-1:0]
- s_wrData  out  XLEN  shared write data
- s_mode  out  4  shared mode
- s_wrEn  out  NUM_SLV  one-hot write strobes
- s_rdEn  out  NUM_SLV  one-hot read strobes
- s_rdata  in  NUM_SLV*XLEN  slave read data; slot k occupies bits [k*XLEN +: XLEN]
- s_outEn  in  NUM_SLV  slave read-data valid
- err_addr  out  XLEN  address of the most recent error
- err_cnt  out  8  saturating error count

## Operation
- Decode:
  - mapped = (m_addr[XLEN-1:ADDRW] == 0) && (slot < NUM_SLV).
  - s_wrEn[slot] = m_wrEn & mapped & !m_busy.
  - s_rdEn[slot] = m_rdEn & mapped & !m_busy.
  - Both strobes are combinational.
- FSM states:
  - IDLE:
    - mapped read: latch slot into pend, clear cnt, go to WAIT.
    - unmapped read: go to ERR.
    - unmapped write: pulse m_err next cycle and capture the error; stay in IDLE.
    - mapped write: no state change.
    - m_rdEn and m_wrEn together, same mapped slot: both strobes issue and the read is tracked.
    - m_rdEn and m_wrEn together, either unmapped: treated as an unmapped read.
  - WAIT:
    - cnt increments each cycle.
    - s_outEn[pend] high: register s_rdata[pend] into m_rdata, pulse m_rdataEn next cycle, return to IDLE.
    - cnt reaches TIMEOUT with no outEn: go to ERR.
    - s_outEn of other slots is ignored.
  - ERR:
    - m_rdata = ERR_DATA; m_rdataEn = 1 and m_err = 1 for one cycle.
    - capture err_addr; err_cnt increments, saturating at 255.
    - return to IDLE.
- m_busy = (state != IDLE).
  - Strobes arriving while busy issue no slave strobe, no error, and no capture.
- err_addr holds the address of the original request; it is latched at request time.

## Timing
- Reset values:
  - state IDLE; m_busy 0, m_rdataEn 0, m_err 0.
  - m_rdata 0, err_addr 0, err_cnt 0, cnt 0.
  - s_wrEn and s_rdEn are 0 for the duration of rst.
- Mapped read issued in cycle 0, slave s_outEn in cycle L (1 <= L <= TIMEOUT): m_rdataEn in cycle L+1.
- Timeout (no outEn through cycle TIMEOUT): m_rdataEn and m_err in cycle TIMEOUT+1.
- An s_outEn in cycle TIMEOUT is accepted as a normal response.
- Unmapped read in cycle 0: error response in cycle 1.
- Unmapped write in cycle 0: m_err pulse in cycle 1, with m_rdataEn 0.
- A new request is accepted in the same cycle as the response pulse, because state is already IDLE.
- s_outEn in cycle 0, the request cycle itself, is ignored.
- rst asserted mid-WAIT: pending transaction dropped; no response is produced; state is IDLE the next cycle.

## Test plan
- NUM_SLV=4: read at 0x404, slot 1 asserts outEn at L=2 with data 0x1234_5678 -> m_rdataEn in cycle 3, m_rdata 0x1234_5678, m_err 0.
- Read at 0x000 with slot 0 silent, TIMEOUT=15 -> cycle 16: m_rdata 0xDEAD_BEEF, m_err 1, err_addr 0x0, err_cnt 1.
- Write to 0x0000_1000 (above ADDRW) -> no s_wrEn bit set; m_err in cycle 1; m_rdataEn 0; err_addr 0x1000.
- Second m_rdEn during WAIT, plus a spurious s_outEn[2] while pend=1 -> no s_rdEn for the second request; response still comes from slot 1 only.
- 300 unmapped writes -> err_cnt saturates at 255.
- rst in cycle 2 of a pending read, then slot outEn in cycle 3 -> no m_rdataEn; m_busy 0; all outputs at reset values.
